note_recorder: RTL
==================

Name: note_recorder

Overview:
- Captures live keyboard performance into an internal song RAM as (octave, note, duration) entries.
- Mirror of the auto-play path: auto-play reads stored songs, this block writes them.
- Exposes a synchronous read port and a song length, so a playback engine can replay the user's recording.
- Sits between the debounced key inputs and the playback/song-select logic.

Parameters:
- DEPTH, 64: song RAM entries; power of two, minimum 4.
- TICK_CYCLES, 1000000: clk cycles per duration tick (10 ms at 100 MHz); benches override to 4.
- DUR_W, 10: duration field width in ticks; saturates at 2^DUR_W-1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- note_keys  in  7  note keys do..si, already debounced, bit0 = do.
- octave_keys  in  2  octave select, same encoding the playback path uses.
- record_en  in  1  level; high = recording session active.
- rd_addr  in  log2(DEPTH)  read address from the playback engine.
- rd_data  out  6+DUR_W  {octave[1:0], note[3:0], dur[DUR_W-1:0]}, one cycle after rd_addr.
- song_len  out  log2(DEPTH)+1  entries written in the last completed session, terminator excluded.
- recording  out  1  high in ARMED or CAPTURE.
- full  out  1  RAM exhausted during the current or last session.
- note_out  out  4  note currently being captured: 0 = rest, 1..7 = do..si.

Behaviour:
- Reset (async assert, sync release): state IDLE; wr_ptr = 0; tick counter = 0; dur = 0; song_len = 0; recording = 0; full = 0; note_out = 0; rd_data = 0. RAM contents are not cleared.
- Input sync: note_keys, octave_keys and record_en pass through 2-FF synchronizers. All timing below counts from the synchronized values.
- Note encode: lowest set bit of note_keys wins, giving code 1..7; no key gives 0 (rest). Encoding is combinational on the synced keys.
- Tick: free-running counter in CAPTURE only. It pulses once every TICK_CYCLES and clears on every entry commit.
- States:
  - IDLE: record_en rising moves to ARMED. At the same transition: wr_ptr = 0, full = 0, recording = 1.
  - ARMED: leading rest is not recorded. The first nonzero code moves to CAPTURE, latching cur_note/cur_oct and setting dur = 0. record_en low returns to IDLE, writes the terminator at address 0, and sets song_len = 0.
  - CAPTURE: dur increments on each tick. A commit occurs on any of:
    - code change;
    - octave change while a note is held;
    - dur reaching its maximum on a tick.
  - Commit: RAM[wr_ptr] = {cur_oct, cur_note, dur}; wr_ptr += 1; cur_* latch the new code/octave; dur = 0. On a saturation commit the same note continues as a new entry.
  - Zero-duration entries (change before the first tick) are dropped: no write and no pointer move; the latched note is simply replaced.
  - Rests inside a session are stored as note 0 with their duration.
  - STOP (one cycle): entered when record_en falls in CAPTURE. It flushes the current entry if dur > 0, then writes the terminator {2'b00, 4'hF, 0} at the next wr_ptr. It sets song_len to the entry count, drops recording, and returns to IDLE.
  - FULL: a commit that leaves wr_ptr = DEPTH-1 sets full and enters FULL. The last slot is reserved for the terminator. FULL ignores keys, drops recording, and waits for record_en low, then writes the terminator at DEPTH-1 with song_len = DEPTH-1.
- Simultaneous events: a commit and the record_en fall in the same cycle means the commit happens first, then STOP. record_en re-rising during STOP is ignored until IDLE.
- note_out: equals cur_note in CAPTURE, 0 otherwise.
- Read port: rd_data is registered from RAM[rd_addr], with one-cycle latency, in all states. A read of the address being written in the same cycle returns the old data.
- Async reset mid-session abandons the session. Previously written RAM remains; song_len = 0.

Decomposition:
- Shared package: note code constants (REST = 0, DO..SI = 1..7, TERM = 4'hF), entry field widths, and an entry pack/unpack function. The playback engine uses the same package.
- One sub-module: song_ram, a simple dual-port RAM (DEPTH x (6+DUR_W), one write port, one registered read port).

Test Plan:
- Reset low mid-CAPTURE -> recording = 0, note_out = 0, song_len = 0, rd_data = 0 next cycle. Release -> IDLE.
- TICK_CYCLES = 4: record_en high, bit0 held 12 cycles, bit2 held 8 cycles, release -> RAM[0] = {00,1,3}, RAM[1] = {00,3,2}, RAM[2] = TERM, song_len = 2.
- Leading rest of 20 cycles, then do for 8 cycles, rest for 8, re for 4, record_en low -> entries {do,2}, {rest,2}, {re,1}, TERM; song_len = 3.
- bit0 and bit4 pressed together -> code 1 recorded. A glitch key held 2 cycles (< 1 tick) -> no entry written.
- DEPTH = 4, five distinct notes of 1 tick each -> full = 1 after the 3rd commit. record_en low -> RAM[3] = TERM, song_len = 3.
- DUR_W = 3, do held 10 ticks -> entries {do,7}, {do,3}, TERM. Read RAM[1] -> rd_data valid exactly 1 cycle after rd_addr = 1.

Source files
------------

// File: rtl/note_recorder_pkg.sv
// note_recorder_pkg: note codes, entry field widths and entry head pack/unpack shared with playback.
package note_recorder_pkg;
  localparam logic [3:0] REST = 4'd0;
  localparam logic [3:0] DO   = 4'd1;
  localparam logic [3:0] RE   = 4'd2;
  localparam logic [3:0] MI   = 4'd3;
  localparam logic [3:0] FA   = 4'd4;
  localparam logic [3:0] SOL  = 4'd5;
  localparam logic [3:0] LA   = 4'd6;
  localparam logic [3:0] SI   = 4'd7;
  localparam logic [3:0] TERM = 4'hF;
  localparam int OCT_W  = 2;
  localparam int NOTE_W = 4;
  localparam int HEAD_W = OCT_W + NOTE_W;
  typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, STOP, FULL} state_t;
  function automatic logic [HEAD_W-1:0] pack_head(input logic [OCT_W-1:0] oct, input logic [NOTE_W-1:0] note);
    return {oct, note};
  endfunction
  function automatic logic [NOTE_W-1:0] head_note(input logic [HEAD_W-1:0] head);
    return head[NOTE_W-1:0];
  endfunction
  function automatic logic [OCT_W-1:0] head_oct(input logic [HEAD_W-1:0] head);
    return head[HEAD_W-1:NOTE_W];
  endfunction
endpackage

// File: rtl/note_recorder_song_ram.sv
// song_ram: simple dual-port song RAM, one write port and one registered read port (old data on collision).
module song_ram #(
  parameter int DEPTH = 64,
  parameter int W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or negedge reset)
    if (!reset) rdata <= '0;
    else rdata <= mem[raddr];
endmodule

// File: rtl/note_recorder.sv
// note_recorder: captures live key presses into song RAM as (octave, note, duration) entries.
module note_recorder
  import note_recorder_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int TICK_CYCLES = 1000000,
  parameter int DUR_W = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [6:0]               note_keys,
  input  logic [1:0]               octave_keys,
  input  logic                     record_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [HEAD_W+DUR_W-1:0]  rd_data,
  output logic [$clog2(DEPTH):0]   song_len,
  output logic                     recording,
  output logic                     full,
  output logic [3:0]               note_out
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TICK_CYCLES + 1);
  localparam int EW = HEAD_W + DUR_W;
  localparam logic [DUR_W-1:0] DMAX = '1;
  logic [6:0] keys_m, keys_s;
  logic [1:0] oct_m, oct_s, cur_oct;
  logic rec_m, rec_s, rec_q;
  state_t state;
  logic [AW-1:0] wr_ptr;
  logic [TW-1:0] tcnt;
  logic [DUR_W-1:0] dur, dur_t;
  logic [3:0] cur_note, code;
  logic tick, chg, ev, wr_entry, full_hit, we;
  logic [EW-1:0] wdata;
  always_ff @(posedge clk or negedge reset)
    if (!reset) {keys_s, keys_m, oct_s, oct_m, rec_q, rec_s, rec_m} <= '0;
    else {keys_s, keys_m, oct_s, oct_m, rec_q, rec_s, rec_m} <= {keys_m, note_keys, oct_m, octave_keys, rec_s, rec_m, record_en};
  // dur_t folds in a tick landing on the same edge as a commit so that tick is not lost
  always_comb begin
    code = REST;
    for (int i = 6; i >= 0; i--) if (keys_s[i]) code = 4'(i + 1);
    tick = state == CAPTURE && tcnt == TW'(TICK_CYCLES - 1);
    dur_t = dur + DUR_W'(tick && dur != DMAX);
    chg = code != cur_note || (cur_note != REST && oct_s != cur_oct);
    ev = chg || !rec_s || (tick && dur_t == DMAX);
    wr_entry = state == CAPTURE && ev && dur_t != '0;
    full_hit = wr_entry && wr_ptr == AW'(DEPTH - 2);
    we = wr_entry || state == STOP || (state == ARMED && !rec_s);
    wdata = wr_entry ? {pack_head(cur_oct, cur_note), dur_t} : {pack_head(2'b00, TERM), DUR_W'(0)};
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      wr_ptr <= '0;
      tcnt <= '0;
      dur <= '0;
      cur_note <= REST;
      cur_oct <= '0;
      song_len <= '0;
      recording <= 1'b0;
      full <= 1'b0;
    end else
      case (state)
        IDLE: if (rec_s && !rec_q) begin
          state <= ARMED;
          wr_ptr <= '0;
          full <= 1'b0;
          recording <= 1'b1;
        end
        ARMED: if (!rec_s) begin
          state <= IDLE;
          song_len <= '0;
          recording <= 1'b0;
        end else if (code != REST) begin
          state <= CAPTURE;
          cur_note <= code;
          cur_oct <= oct_s;
          dur <= '0;
          tcnt <= '0;
        end
        CAPTURE: if (ev) begin
          cur_note <= code;
          cur_oct <= oct_s;
          dur <= '0;
          tcnt <= '0;
          if (wr_entry) wr_ptr <= wr_ptr + 1'b1;
          if (full_hit) full <= 1'b1;
          if (!rec_s || full_hit) recording <= 1'b0;
          state <= !rec_s ? STOP : full_hit ? FULL : CAPTURE;
        end else begin
          dur <= dur_t;
          tcnt <= tick ? '0 : tcnt + 1'b1;
        end
        FULL: if (!rec_s) state <= STOP;
        STOP: begin
          state <= IDLE;
          song_len <= {1'b0, wr_ptr};
          recording <= 1'b0;
        end
        default: state <= IDLE;
      endcase
  assign note_out = state == CAPTURE ? cur_note : REST;
  song_ram #(.DEPTH(DEPTH), .W(EW)) u_ram (
    .clk(clk), .reset(reset), .we(we), .waddr(wr_ptr), .wdata(wdata),
    .raddr(rd_addr), .rdata(rd_data)
  );
endmodule
